// File: rtl/jtag_bs_chain_pkg.sv
// Shared types for the boundary-scan data register: output mode encoding
// and the fixed chain geometry limits.
package jtag_bs_chain_pkg;

    typedef enum logic [1:0] {
        DR_TRANSP = 2'd0,
        DR_EXTEST = 2'd1,
        DR_SAFE   = 2'd2,
        DR_HOLD   = 2'd3
    } dr_mode_e;

    localparam int unsigned MIN_WIDTH = 1;

endpackage

// File: rtl/jtag_bs_chain_bs_slice.sv
// One boundary-scan cell: a capture/shift flop feeding an update (hold) flop.
// Strobes arrive already qualified by select, priority and mode from the top.
module bs_slice #(
    parameter logic RST_BIT       = 1'b0,
    parameter logic CAPT_MASK_BIT = 1'b0,
    parameter logic CAPT_FIX_BIT  = 1'b0
) (
    input  logic tck_i,
    input  logic trst_ni,
    input  logic capture_i,
    input  logic shift_i,
    input  logic update_i,
    input  logic data_i,
    input  logic ser_i,
    output logic sr_o,
    output logic upd_o
);

    logic sr_q;
    logic sr_d;
    logic upd_q;
    logic upd_d;

    always_comb begin
        sr_d  = sr_q;
        upd_d = upd_q;
        if (capture_i) begin
            sr_d = CAPT_MASK_BIT ? CAPT_FIX_BIT : data_i;
        end else if (shift_i) begin
            sr_d = ser_i;
        end
        // Update copies the pre-edge shift value, independent of capture/shift.
        if (update_i) begin
            upd_d = sr_q;
        end
    end

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            sr_q  <= 1'b0;
            upd_q <= RST_BIT;
        end else begin
            sr_q  <= sr_d;
            upd_q <= upd_d;
        end
    end

    assign sr_o  = sr_q;
    assign upd_o = upd_q;

endmodule

// File: rtl/jtag_bs_chain.sv
// WIDTH-cell boundary-scan data register with shift-length checking and a
// selectable parallel output mode (transparent / extest / safe / hold).
module jtag_bs_chain
    import jtag_bs_chain_pkg::*;
#(
    parameter int unsigned       WIDTH     = 16,
    parameter int unsigned       CNT_W     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter logic [WIDTH-1:0]  SAFE_VAL  = '0,
    parameter logic [WIDTH-1:0]  CAPT_MASK = '0,
    parameter logic [WIDTH-1:0]  CAPT_FIX  = '0
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             sel_i,
    input  logic             capture_dr_i,
    input  logic             shift_dr_i,
    input  logic             update_dr_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             tdi_i,
    output logic [WIDTH-1:0] data_o,
    output logic             tdo_o,
    output logic [CNT_W-1:0] shift_cnt_o,
    output logic             len_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);

    dr_mode_e mode;
    logic     cap_en;
    logic     shift_en;
    logic     upd_en;

    assign mode     = dr_mode_e'(mode_i);
    assign cap_en   = sel_i & capture_dr_i;
    assign shift_en = sel_i & shift_dr_i & ~capture_dr_i;
    assign upd_en   = sel_i & update_dr_i & (mode != DR_HOLD);

    // chain[WIDTH] is TDI; chain[i] is the shift bit of cell i, chain[0] drives TDO.
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] upd_bits;

    assign chain[WIDTH] = tdi_i;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            bs_slice #(
                .RST_BIT      (RESET_VAL[gi]),
                .CAPT_MASK_BIT(CAPT_MASK[gi]),
                .CAPT_FIX_BIT (CAPT_FIX[gi])
            ) u_slice (
                .tck_i    (tck_i),
                .trst_ni  (trst_ni),
                .capture_i(cap_en),
                .shift_i  (shift_en),
                .update_i (upd_en),
                .data_i   (data_i[gi]),
                .ser_i    (chain[gi+1]),
                .sr_o     (chain[gi]),
                .upd_o    (upd_bits[gi])
            );
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             len_err_q;
    logic             len_err_d;

    always_comb begin
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        if (cap_en) begin
            cnt_d     = '0;
            len_err_d = 1'b0;
        end else if (shift_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // A saturated count can never equal WIDTH, so overlong shifts still flag.
        if (upd_en) begin
            len_err_d = (cnt_q != CNT_WIDTH);
        end
    end

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        data_o = upd_bits;
        unique case (mode)
            DR_TRANSP: data_o = data_i;
            DR_EXTEST: data_o = upd_bits;
            DR_SAFE:   data_o = SAFE_VAL;
            DR_HOLD:   data_o = upd_bits;
            default:   data_o = upd_bits;
        endcase
    end

    assign tdo_o       = chain[0];
    assign shift_cnt_o = cnt_q;
    assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_jtag_bs_chain.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized strobes checked every cycle against a word-level model.
module tb_jtag_bs_chain;

    localparam logic [15:0] RST_V  = 16'hA5A5;
    localparam logic [15:0] SAFE_V = 16'h5AC3;
    localparam logic [15:0] MASKS [2] = '{16'h0000, 16'h000F};
    localparam logic [15:0] FIXES [2] = '{16'h0000, 16'h0005};

    logic        tck = 1'b0;
    logic        trst_n;
    logic        sel;
    logic        cap;
    logic        sh;
    logic        upd;
    logic [1:0]  mode;
    logic [15:0] data_in;
    logic        tdi;

    logic [15:0] dut_data [2];
    logic        dut_tdo  [2];
    logic [7:0]  dut_cnt  [2];
    logic        dut_len  [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 tck = ~tck;

    jtag_bs_chain #(
        .WIDTH(16), .CNT_W(8), .RESET_VAL(RST_V), .SAFE_VAL(SAFE_V),
        .CAPT_MASK(16'h0000), .CAPT_FIX(16'h0000)
    ) dut0 (
        .tck_i(tck), .trst_ni(trst_n), .sel_i(sel), .capture_dr_i(cap),
        .shift_dr_i(sh), .update_dr_i(upd), .mode_i(mode), .data_i(data_in),
        .tdi_i(tdi), .data_o(dut_data[0]), .tdo_o(dut_tdo[0]),
        .shift_cnt_o(dut_cnt[0]), .len_err_o(dut_len[0])
    );

    jtag_bs_chain #(
        .WIDTH(16), .CNT_W(8), .RESET_VAL(RST_V), .SAFE_VAL(SAFE_V),
        .CAPT_MASK(16'h000F), .CAPT_FIX(16'h0005)
    ) dut1 (
        .tck_i(tck), .trst_ni(trst_n), .sel_i(sel), .capture_dr_i(cap),
        .shift_dr_i(sh), .update_dr_i(upd), .mode_i(mode), .data_i(data_in),
        .tdi_i(tdi), .data_o(dut_data[1]), .tdo_o(dut_tdo[1]),
        .shift_cnt_o(dut_cnt[1]), .len_err_o(dut_len[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: shift register and update register as plain integers.
    logic [15:0] m_sr  [2];
    logic [15:0] m_upd [2];
    int          m_cnt;
    logic        m_len;
    bit          m_valid = 1'b0;

    always @(posedge tck) begin
        if (!trst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_sr[i]  = 16'h0000;
                m_upd[i] = RST_V;
            end
            m_cnt   = 0;
            m_len   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && sel) begin
            if (upd && mode != 2'd3) begin
                for (int i = 0; i < 2; i++) m_upd[i] = m_sr[i];
                m_len = (m_cnt != 16);
            end
            if (cap) begin
                for (int i = 0; i < 2; i++)
                    m_sr[i] = (data_in & ~MASKS[i]) | (FIXES[i] & MASKS[i]);
                m_cnt = 0;
                m_len = 1'b0;
            end else if (sh) begin
                for (int i = 0; i < 2; i++) m_sr[i] = (m_sr[i] >> 1) | (16'(tdi) << 15);
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
    end

    always @(negedge tck) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                logic [15:0] exp_d;
                case (mode)
                    2'd0:    exp_d = data_in;
                    2'd2:    exp_d = SAFE_V;
                    default: exp_d = m_upd[i];
                endcase
                check($sformatf("model.data_o[%0d]", i), 32'(dut_data[i]), 32'(exp_d));
                check($sformatf("model.tdo_o[%0d]", i), 32'(dut_tdo[i]), 32'(m_sr[i][0]));
                check($sformatf("model.cnt[%0d]", i), 32'(dut_cnt[i]), 32'(m_cnt));
                check($sformatf("model.len_err[%0d]", i), 32'(dut_len[i]), 32'(m_len));
            end
        end
    end

    task automatic tick();
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic strobes(input logic c, input logic s, input logic u, input logic t);
        cap = c; sh = s; upd = u; tdi = t;
    endtask

    logic [15:0] tdo_exp;
    logic [15:0] beef;
    logic [3:0]  nib;

    initial begin
        trst_n = 1'b0; sel = 1'b0; mode = 2'd1; data_in = 16'h0000;
        strobes(0, 0, 0, 0);
        tdo_exp = 16'h1234;
        beef    = 16'hBEEF;

        // Reset state
        tick();
        trst_n = 1'b1;
        check("rst.data_o", 32'(dut_data[0]), 32'h0000A5A5);
        check("rst.tdo_o", 32'(dut_tdo[0]), 32'h0);
        check("rst.cnt", 32'(dut_cnt[0]), 32'h0);
        check("rst.len_err", 32'(dut_len[0]), 32'h0);

        // Capture 0x1234 and shift it out LSB first
        sel = 1'b1; data_in = 16'h1234;
        strobes(1, 0, 0, 0);
        tick();
        strobes(0, 1, 0, 0);
        nib = 4'h0;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("shout.tdo[%0d]", j), 32'(dut_tdo[0]), 32'(tdo_exp[j]));
            if (j < 4) nib[j] = dut_tdo[1];
            tick();
        end
        check("shout.cnt", 32'(dut_cnt[0]), 32'd16);
        check("captmask.nibble", 32'(nib), 32'h5);

        // Shift in 0xBEEF and update
        strobes(1, 0, 0, 0);
        tick();
        for (int j = 0; j < 16; j++) begin
            strobes(0, 1, 0, beef[j]);
            tick();
        end
        strobes(0, 0, 1, 0);
        tick();
        strobes(0, 0, 0, 0);
        check("shin.data_o", 32'(dut_data[0]), 32'h0000BEEF);
        check("shin.len_err", 32'(dut_len[0]), 32'h0);

        // Output modes
        mode = 2'd0; data_in = 16'h3C5A; #1;
        check("mode.transp", 32'(dut_data[0]), 32'h00003C5A);
        mode = 2'd2; #1;
        check("mode.safe", 32'(dut_data[0]), 32'h00005AC3);
        mode = 2'd3; data_in = 16'h0000;
        strobes(1, 0, 0, 0);
        tick();
        for (int j = 0; j < 16; j++) begin
            strobes(0, 1, 0, 0);
            tick();
        end
        strobes(0, 0, 1, 0);
        tick();
        strobes(0, 0, 0, 0);
        check("mode.hold", 32'(dut_data[0]), 32'h0000BEEF);
        mode = 2'd1; #1;
        check("mode.hold_exit", 32'(dut_data[0]), 32'h0000BEEF);

        // Length error, clear on capture, saturation
        strobes(1, 0, 0, 0);
        tick();
        for (int j = 0; j < 15; j++) begin
            strobes(0, 1, 0, 0);
            tick();
        end
        strobes(0, 0, 1, 0);
        tick();
        check("lenerr.set", 32'(dut_len[0]), 32'h1);
        strobes(1, 0, 0, 0);
        tick();
        check("lenerr.clear", 32'(dut_len[0]), 32'h0);
        for (int j = 0; j < 300; j++) begin
            strobes(0, 1, 0, 0);
            tick();
        end
        check("sat.cnt", 32'(dut_cnt[0]), 32'd255);
        strobes(0, 0, 1, 0);
        tick();
        check("sat.len_err", 32'(dut_len[0]), 32'h1);
        check("sat.data_o", 32'(dut_data[0]), 32'h0000);

        // Select gating
        sel = 1'b0; data_in = 16'hFFFF;
        strobes(1, 1, 1, 1);
        tick();
        check("gate.cnt", 32'(dut_cnt[0]), 32'd255);
        check("gate.len_err", 32'(dut_len[0]), 32'h1);
        check("gate.data_o", 32'(dut_data[0]), 32'h0000);

        // Capture beats shift
        sel = 1'b1;
        strobes(1, 1, 0, 0);
        tick();
        check("prio.cnt", 32'(dut_cnt[0]), 32'd0);
        check("prio.tdo", 32'(dut_tdo[0]), 32'h1);

        // Reset mid-shift
        for (int j = 0; j < 8; j++) begin
            strobes(0, 1, 0, 1);
            tick();
        end
        trst_n = 1'b0;
        tick();
        trst_n = 1'b1;
        strobes(0, 0, 0, 0);
        check("midrst.tdo", 32'(dut_tdo[0]), 32'h0);
        check("midrst.cnt", 32'(dut_cnt[0]), 32'h0);
        check("midrst.data_o", 32'(dut_data[0]), 32'h0000A5A5);

        // Randomized traffic, checked every cycle by the model
        for (int k = 0; k < 3000; k++) begin
            int r;
            trst_n  = ($urandom_range(0, 99) != 0);
            sel     = ($urandom_range(0, 7) != 0);
            mode    = 2'($urandom_range(0, 3));
            data_in = 16'($urandom);
            r       = $urandom_range(0, 9);
            case (r)
                0:       strobes(1, 0, 0, 1'($urandom));
                1:       strobes(1, 1, 0, 1'($urandom));
                2:       strobes(0, 0, 1, 1'($urandom));
                3:       strobes(0, 1, 1, 1'($urandom));
                4:       strobes(0, 0, 0, 1'($urandom));
                default: strobes(0, 1, 0, 1'($urandom));
            endcase
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
